time_set_ctrl: RTL and testbench

//  Run/set sequencer for the six-digit HH:MM:SS time counter.
//  - RUN: forwards the 1 Hz tick as the seconds advance strobe, with digit carry chaining enabled.
//  - SET: freezes seconds and lets the user step hours, then minutes, with one increment button.
//  - Sits between the debounced buttons / 1 Hz divider and the counter's 3-bit advance input and mode input.

---
 rtl/time_set_ctrl.sv | 165 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set sequencer for the HH:MM:SS counter.
// In RUN it forwards the 1 Hz tick as the seconds advance. In SET it freezes
// seconds and steps hours or minutes from a single increment button, with
// hold-to-repeat, display blinking of the selected field and an idle timeout.
module time_set_ctrl #(
    parameter logic [23:0] HOLD_CYCLES   = 24'd12_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd3_000_000,
    parameter logic [7:0]  TIMEOUT_TICKS = 8'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [2:0] adv,
    output logic       mode,
    output logic [1:0] sel,
    output logic       blink
);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

    state_t      state_q, state_n;
    logic        mode_hist, inc_hist;
    logic        mode_press, inc_press;
    logic        inc_act, inc_act_n;    // current inc hold began with a press in this state
    logic        rep_on, rep_on_n;      // initial hold delay has elapsed
    logic [23:0] hold_cnt, hold_n;
    logic [23:0] rep_cnt, rep_n;
    logic [7:0]  tmo_cnt, tmo_n;
    logic [1:0]  bhold, bhold_n;        // ticks left with the field forced visible
    logic        strobe;
    logic [2:0]  adv_n;
    logic        mode_n, blink_n;
    logic [1:0]  sel_n;

    assign mode_press = btn_mode & ~mode_hist;
    assign inc_press  = btn_inc & ~inc_hist;

    // State, counters and registered outputs; history regs reset high so a
    // button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            mode_hist <= 1'b1;
            inc_hist  <= 1'b1;
            inc_act   <= 1'b0;
            rep_on    <= 1'b0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            tmo_cnt   <= '0;
            bhold     <= '0;
            adv       <= 3'b000;
            mode      <= 1'b1;
            sel       <= 2'b00;
            blink     <= 1'b1;
        end else begin
            state_q   <= state_n;
            mode_hist <= btn_mode;
            inc_hist  <= btn_inc;
            inc_act   <= inc_act_n;
            rep_on    <= rep_on_n;
            hold_cnt  <= hold_n;
            rep_cnt   <= rep_n;
            tmo_cnt   <= tmo_n;
            bhold     <= bhold_n;
            adv       <= adv_n;
            mode      <= mode_n;
            sel       <= sel_n;
            blink     <= blink_n;
        end
    end

    // Next state, auto-repeat, timeout and blink logic.
    always_comb begin
        state_n   = state_q;
        inc_act_n = inc_act;
        rep_on_n  = rep_on;
        hold_n    = hold_cnt;
        rep_n     = rep_cnt;
        tmo_n     = tmo_cnt;
        bhold_n   = bhold;
        blink_n   = blink;
        strobe    = 1'b0;
        adv_n     = 3'b000;

        case (state_q)
            RUN: begin
                adv_n[0] = tick_1hz;
                if (mode_press) state_n = SET_HR;
            end
            SET_HR, SET_MIN: begin
                if (!btn_inc) begin
                    inc_act_n = 1'b0;
                    rep_on_n  = 1'b0;
                    hold_n    = '0;
                    rep_n     = '0;
                end else if (inc_press) begin
                    inc_act_n = 1'b1;
                    rep_on_n  = 1'b0;
                    hold_n    = 24'd1;
                    rep_n     = '0;
                    strobe    = 1'b1;
                end else if (inc_act) begin
                    if (!rep_on) begin
                        if (hold_cnt == HOLD_CYCLES - 24'd1) begin
                            strobe   = 1'b1;
                            rep_on_n = 1'b1;
                            rep_n    = 24'd1;
                        end else begin
                            hold_n = hold_cnt + 24'd1;
                        end
                    end else if (rep_cnt == REPEAT_CYCLES) begin
                        strobe = 1'b1;
                        rep_n  = 24'd1;
                    end else begin
                        rep_n = rep_cnt + 24'd1;
                    end
                end

                if (strobe || inc_press) tmo_n = '0;
                else if (tick_1hz)       tmo_n = tmo_cnt + 8'd1;

                if (strobe) begin
                    blink_n = 1'b1;
                    bhold_n = 2'd2;
                end else if (tick_1hz) begin
                    if (bhold != 2'd0) begin
                        bhold_n = bhold - 2'd1;
                        blink_n = 1'b1;
                    end else begin
                        blink_n = ~blink;
                    end
                end

                if (strobe) adv_n = (state_q == SET_HR) ? 3'b100 : 3'b010;

                if (mode_press)                 state_n = (state_q == SET_HR) ? SET_MIN : RUN;
                else if (tmo_n == TIMEOUT_TICKS) state_n = RUN;
            end
            default: state_n = RUN;
        endcase

        // Any state change drops a pending field strobe and restarts all timing;
        // a held inc must be released and pressed again to act in the new state.
        if (state_n != state_q) begin
            adv_n[2:1] = 2'b00;
            inc_act_n  = 1'b0;
            rep_on_n   = 1'b0;
            hold_n     = '0;
            rep_n      = '0;
            tmo_n      = '0;
            bhold_n    = '0;
            blink_n    = 1'b1;
        end

        mode_n = (state_n == RUN);
        case (state_n)
            SET_HR:  sel_n = 2'b10;
            SET_MIN: sel_n = 2'b01;
            default: sel_n = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a scoreboard of expected adv strobes.
module tb_time_set_ctrl;

    localparam logic [23:0] HOLD = 24'd8;
    localparam logic [23:0] REP  = 24'd4;
    localparam logic [7:0]  TMO  = 8'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [2:0] adv;
    logic       mode;
    logic [1:0] sel;
    logic       blink;

    time_set_ctrl #(
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_1hz(tick_1hz),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .adv(adv),
        .mode(mode),
        .sel(sel),
        .blink(blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [2:0] a;
    } exp_t;
    exp_t q[$];

    int  n_assert = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every nonzero adv must match the oldest expected strobe.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].t < cyc) begin
                e = q.pop_front();
                check("adv_missing_at_cycle", 32'(cyc), 32'(e.t));
            end
            if (adv !== 3'b000) begin
                if (q.size() == 0) begin
                    check("adv_unexpected", 32'(adv), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("adv_cycle", 32'(cyc), 32'(e.t));
                    check("adv_value", 32'(adv), 32'(e.a));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_tick(input bit in_run);
        tick_1hz = 1'b1;
        if (in_run) q.push_back('{cyc + 1, 3'b001});
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic inc_tap(input logic [2:0] exp_adv);
        btn_inc = 1'b1;
        q.push_back('{cyc + 1, exp_adv});
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic mode_tap();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_adv"},   32'(adv),   32'(3'b000));
        check({tag, "_mode"},  32'(mode),  32'(1));
        check({tag, "_sel"},   32'(sel),   32'(2'b00));
        check({tag, "_blink"}, 32'(blink), 32'(1));
    endtask

    int e0;

    initial begin
        // 1: reset and RUN forwarding of ticks
        rst = 1'b1;
        idle(2);
        check_reset_vals("reset");
        mon_en = 1'b1;
        rst = 1'b0;
        idle(2);
        for (int i = 0; i < 5; i++) begin
            do_tick(1'b1);
            idle(19);
            check("run_mode", 32'(mode), 32'(1));
            check("run_sel", 32'(sel), 32'(2'b00));
        end

        // 2: SET_HR, ticks dropped, short inc presses, blink behaviour
        mode_tap();
        check("sethr_sel", 32'(sel), 32'(2'b10));
        check("sethr_mode", 32'(mode), 32'(0));
        check("sethr_blink_entry", 32'(blink), 32'(1));
        do_tick(1'b0);
        check("blink_toggle_off", 32'(blink), 32'(0));
        idle(5);
        do_tick(1'b0);
        check("blink_toggle_on", 32'(blink), 32'(1));
        idle(5);
        inc_tap(3'b100);
        check("blink_after_strobe", 32'(blink), 32'(1));
        idle(5);
        do_tick(1'b0);
        check("blink_forced", 32'(blink), 32'(1));
        idle(5);
        inc_tap(3'b100);
        idle(3);
        mode_tap();
        check("setmin_sel", 32'(sel), 32'(2'b01));

        // 3: hold inc for 20 cycles in SET_MIN
        e0 = cyc;
        btn_inc = 1'b1;
        q.push_back('{e0 + 1,  3'b010});
        q.push_back('{e0 + 8,  3'b010});
        q.push_back('{e0 + 12, 3'b010});
        q.push_back('{e0 + 16, 3'b010});
        q.push_back('{e0 + 20, 3'b010});
        step();
        idle(19);
        btn_inc = 1'b0;
        idle(10);
        check("hold_blink", 32'(blink), 32'(1));
        check("hold_sel", 32'(sel), 32'(2'b01));

        // 4: timeout from SET_HR, and extension by an inc press
        mode_tap();
        check("back_to_run_sel", 32'(sel), 32'(2'b00));
        mode_tap();
        do_tick(1'b0);
        idle(3);
        do_tick(1'b0);
        idle(3);
        check("tmo_not_yet", 32'(sel), 32'(2'b10));
        do_tick(1'b0);
        check("tmo_sel", 32'(sel), 32'(2'b00));
        check("tmo_mode", 32'(mode), 32'(1));
        idle(3);
        mode_tap();
        do_tick(1'b0);
        idle(3);
        do_tick(1'b0);
        idle(3);
        inc_tap(3'b100);
        do_tick(1'b0);
        idle(3);
        do_tick(1'b0);
        idle(3);
        check("tmo_extended", 32'(sel), 32'(2'b10));
        do_tick(1'b0);
        check("tmo_ext_sel", 32'(sel), 32'(2'b00));
        check("tmo_ext_mode", 32'(mode), 32'(1));
        idle(3);

        // 5: mode+tick in RUN, then mode+inc in SET_HR
        btn_mode = 1'b1;
        tick_1hz = 1'b1;
        q.push_back('{cyc + 1, 3'b001});
        step();
        btn_mode = 1'b0;
        tick_1hz = 1'b0;
        step();
        check("mode_tick_sel", 32'(sel), 32'(2'b10));
        idle(3);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        check("mode_inc_adv", 32'(adv), 32'(3'b000));
        step();
        check("mode_inc_sel", 32'(sel), 32'(2'b01));
        idle(3);

        // 6: reset during auto-repeat, held inc afterwards
        e0 = cyc;
        btn_inc = 1'b1;
        q.push_back('{e0 + 1, 3'b010});
        q.push_back('{e0 + 8, 3'b010});
        step();
        idle(8);
        rst = 1'b1;
        step();
        check_reset_vals("midrst");
        rst = 1'b0;
        idle(30);
        mode_tap();
        idle(20);
        check("held_inc_sel", 32'(sel), 32'(2'b10));
        btn_inc = 1'b0;
        idle(5);

        check("queue_empty", 32'(q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
